// File: rtl/spi_slave_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | spi_slave_tx: SPI mode-0 slave transmitter, 32-bit LSB-first words,      |
// | fed from main memory by DMA bursts into a local prefetch FIFO.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module spi_slave_tx #(
    parameter int FIFO_WORDS  = 16,
    parameter int BURST_WORDS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  register_num,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic        wen,
    input  logic        ren,
    output logic        ready,
    output logic        qpimem_arb_do_read,
    input  logic        qpimem_arb_next_word,
    output logic [31:0] qpimem_arb_addr,
    input  logic [31:0] qpimem_arb_rdata,
    input  logic        SCK,
    input  logic        CS,
    output logic        MISO
);

    localparam int AW = $clog2(FIFO_WORDS);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BURST_WORDS + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } dma_state_t;

    dma_state_t state, next_state;

    logic        sck_s1, sck_s2, sck_d;
    logic        cs_s1, cs_s2, cs_d;
    logic        enable, underflow, armed, discard;
    logic [31:0] src_addr, words_total, words_sent, words_left;
    logic [BW-1:0] burst_left;
    logic [CW-1:0] wr_ptr, rd_ptr;
    logic [31:0] fifo_mem [FIFO_WORDS];
    logic [31:0] shreg;
    logic [5:0]  bit_cnt;

    logic          sck_rise, sck_fall, cs_rise, cs_fall, cs_low;
    logic [CW-1:0] count, free;
    logic          fifo_empty;
    logic [BW-1:0] burst_len;
    logic          start, arm_write, fifo_clear, accept;
    logic          pop, shift_step, count_word;
    logic [31:0]   pop_word;
    logic [31:0]   rd_mux;

    assign sck_rise = sck_s2 & ~sck_d;
    assign sck_fall = ~sck_s2 & sck_d;
    assign cs_rise  = cs_s2 & ~cs_d;
    assign cs_fall  = ~cs_s2 & cs_d;
    assign cs_low   = ~cs_s2;

    assign count      = wr_ptr - rd_ptr;
    assign free       = CW'(FIFO_WORDS) - count;
    assign fifo_empty = (count == '0);
    assign pop_word   = fifo_empty ? 32'd0 : fifo_mem[rd_ptr[AW-1:0]];

    assign burst_len  = (words_left < 32'(BURST_WORDS)) ? words_left[BW-1:0] : BW'(BURST_WORDS);
    assign arm_write  = wen && (register_num == 3'd1) && cs_s2;
    assign fifo_clear = arm_write || cs_rise;
    assign start      = (state == ST_IDLE) && enable && armed && (words_left != 32'd0) &&
                        (32'(free) >= 32'(burst_len)) && !fifo_clear;
    // Words of a burst whose FIFO was flushed mid-flight are read but dropped.
    assign accept     = qpimem_arb_next_word && (state == ST_BURST) && !discard && !fifo_clear;

    assign pop        = enable && ((cs_fall) || (sck_fall && cs_low && (bit_cnt == 6'd32)));
    assign shift_step = enable && sck_fall && cs_low && (bit_cnt != 6'd0) && (bit_cnt < 6'd32);
    assign count_word = sck_rise && cs_low && (bit_cnt == 6'd32);

    assign qpimem_arb_do_read = (state == ST_BURST);

    always_comb begin
        rd_mux = 32'd0;
        case (register_num)
            3'd0:    rd_mux = {28'd0, armed, underflow, cs_low, enable};
            3'd1:    rd_mux = src_addr;
            3'd2:    rd_mux = words_total;
            3'd3:    rd_mux = words_sent;
            default: rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_BURST;
            ST_BURST: if (qpimem_arb_next_word && (burst_left == BW'(1))) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr[AW-1:0]] <= qpimem_arb_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_s1 <= 1'b0; sck_s2 <= 1'b0; sck_d <= 1'b0;
            cs_s1  <= 1'b0; cs_s2  <= 1'b0; cs_d  <= 1'b0;
            enable <= 1'b0; underflow <= 1'b0; armed <= 1'b0; discard <= 1'b0;
            src_addr <= 32'd0; words_total <= 32'd0; words_sent <= 32'd0;
            words_left <= 32'd0; qpimem_arb_addr <= 32'd0; burst_left <= '0;
            wr_ptr <= '0; rd_ptr <= '0;
            shreg <= 32'd0; bit_cnt <= 6'd0; MISO <= 1'b0;
            data_out <= 32'd0; ready <= 1'b0;
        end else begin
            sck_s1 <= SCK; sck_s2 <= sck_s1; sck_d <= sck_s2;
            cs_s1  <= CS;  cs_s2  <= cs_s1;  cs_d  <= cs_s2;

            ready <= wen | ren;
            if (ren) data_out <= rd_mux;

            if (wen) begin
                case (register_num)
                    3'd0:    enable      <= data_in[0];
                    3'd1:    src_addr    <= data_in;
                    3'd2:    words_total <= data_in;
                    default: ;
                endcase
            end

            // Only an empty pop for a word that was actually programmed is an error.
            if (pop && fifo_empty && (words_sent < words_total)) underflow <= 1'b1;
            else if (wen && (register_num == 3'd0) && !data_in[2]) underflow <= 1'b0;

            if (arm_write)    armed <= 1'b1;
            else if (cs_rise) armed <= 1'b0;

            if (arm_write) begin
                qpimem_arb_addr <= data_in;
                words_left      <= words_total;
            end else if (accept) begin
                qpimem_arb_addr <= qpimem_arb_addr + 32'd4;
                words_left      <= words_left - 32'd1;
            end

            if (arm_write)       words_sent <= 32'd0;
            else if (count_word) words_sent <= words_sent + 32'd1;

            if (start) burst_left <= burst_len;
            else if ((state == ST_BURST) && qpimem_arb_next_word) burst_left <= burst_left - BW'(1);

            if (next_state == ST_IDLE)                  discard <= 1'b0;
            else if (fifo_clear && (state == ST_BURST)) discard <= 1'b1;

            if (fifo_clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (accept)              wr_ptr <= wr_ptr + CW'(1);
                if (pop && !fifo_empty)  rd_ptr <= rd_ptr + CW'(1);
            end

            if (cs_rise) begin
                bit_cnt <= 6'd0;
            end else if (pop) begin
                shreg   <= pop_word;
                bit_cnt <= 6'd1;
            end else if (shift_step) begin
                bit_cnt <= bit_cnt + 6'd1;
            end

            if (!cs_low || !enable) MISO <= 1'b0;
            else if (pop)           MISO <= pop_word[0];
            else if (shift_step)    MISO <= shreg[bit_cnt[4:0]];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_spi_slave_tx: directed/randomised bench with memory and SPI master.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_spi_slave_tx;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  register_num = 3'd0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] data_out;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic        ready;
    logic        do_read;
    logic        next_word = 1'b0;
    logic [31:0] addr;
    logic [31:0] rdata = 32'd0;
    logic        SCK = 1'b0;
    logic        CS = 1'b1;
    logic        MISO;

    int passed = 0;
    int total  = 0;
    int mem_delay = 0;
    int wait_cnt  = 0;
    logic prev_dr = 1'b0;
    logic [31:0] addr_log[$];
    int          burst_lens[$];
    logic        rx_bits[$];

    spi_slave_tx #(.FIFO_WORDS(16), .BURST_WORDS(8)) dut (
        .clk(clk), .reset(reset), .register_num(register_num), .data_in(data_in),
        .data_out(data_out), .wen(wen), .ren(ren), .ready(ready),
        .qpimem_arb_do_read(do_read), .qpimem_arb_next_word(next_word),
        .qpimem_arb_addr(addr), .qpimem_arb_rdata(rdata),
        .SCK(SCK), .CS(CS), .MISO(MISO)
    );

    always #5 clk = ~clk;

    // Memory: returns addr^KEY, optional initial latency, random gaps.
    always @(negedge clk) begin
        if (do_read && !prev_dr) begin
            burst_lens.push_back(0);
            wait_cnt = 0;
        end
        prev_dr   = do_read;
        next_word = 1'b0;
        if (do_read && !reset) begin
            if (wait_cnt < mem_delay) begin
                wait_cnt++;
            end else if ($urandom_range(0, 3) != 0) begin
                next_word = 1'b1;
                rdata     = addr ^ KEY;
                addr_log.push_back(addr);
                burst_lens[burst_lens.size() - 1] += 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic wr(input logic [2:0] r, input logic [31:0] d);
        @(negedge clk);
        register_num = r; data_in = d; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
        check("ready_after_write", {31'd0, ready}, 32'd1);
    endtask

    task automatic rd(input logic [2:0] r, output logic [31:0] d);
        @(negedge clk);
        register_num = r; ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
        d = data_out;
    endtask

    task automatic wait_dma(input int nwords, input string tag);
        int cyc = 0;
        while ((addr_log.size() < nwords || do_read) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(addr_log.size()), 32'(nwords));
        check({tag, "_idle"}, {31'd0, do_read}, 32'd0);
    endtask

    task automatic cs_assert();
        @(negedge clk);
        CS = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic sck_run(input int n);
        for (int i = 0; i < n; i++) begin
            SCK = 1'b1;
            rx_bits.push_back(MISO);
            repeat (8) @(negedge clk);
            SCK = 1'b0;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic cs_release();
        CS = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    function automatic logic [31:0] rx_word(input int i);
        logic [31:0] w;
        for (int j = 0; j < 32; j++) w[j] = rx_bits[32 * i + j];
        return w;
    endfunction

    // Reference: word i of an n-word transfer from src; zeros past the end.
    function automatic logic [31:0] exp_word(input logic [31:0] src, input int n, input int i);
        return (i < n) ? ((src + 32'(4 * i)) ^ KEY) : 32'd0;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v, src, tmp;
        logic [7:0]  b;
        int cyc;

        repeat (3) @(negedge clk);
        check("rst_do_read", {31'd0, do_read}, 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_miso", {31'd0, MISO}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        rd(3'd0, v);
        check("reg0_after_reset", v, 32'd0);

        // Single 4-word burst from 0x1000, then a 128-clock transfer.
        wr(3'd0, 32'd1);
        wr(3'd2, 32'd4);
        addr_log.delete(); burst_lens.delete();
        wr(3'd1, 32'h1000);
        wait_dma(4, "t1_words");
        check("t1_nbursts", 32'(burst_lens.size()), 32'd1);
        check("t1_len", 32'(burst_lens[0]), 32'd4);
        for (int i = 0; i < 4; i++) check("t1_addr", addr_log[i], 32'h1000 + 32'(4 * i));
        rx_bits.delete();
        cs_assert();
        sck_run(128);
        for (int i = 0; i < 4; i++) check("t2_word", rx_word(i), exp_word(32'h1000, 4, i));
        rd(3'd3, v);
        check("t2_reg3", v, 32'd4);
        rd(3'd0, v);
        check("t2_reg0_active", v, 32'hB);
        cs_release();
        rd(3'd0, v);
        check("t2_reg0_idle", v, 32'h1);

        // 20 words into a 16-deep FIFO: 8+8, refill of 4 after four pops.
        src = $urandom & 32'h00FF_FFF0;
        wr(3'd2, 32'd20);
        addr_log.delete(); burst_lens.delete();
        wr(3'd1, src);
        wait_dma(16, "t3_fill");
        repeat (50) @(negedge clk);
        check("t3_nbursts_full", 32'(burst_lens.size()), 32'd2);
        check("t3_len0", 32'(burst_lens[0]), 32'd8);
        check("t3_len1", 32'(burst_lens[1]), 32'd8);
        check("t3_last_addr", addr_log[15], src + 32'd60);
        rx_bits.delete();
        cs_assert();
        sck_run(95);
        repeat (20) @(negedge clk);
        check("t3_no_early_burst", 32'(burst_lens.size()), 32'd2);
        sck_run(1);
        wait_dma(20, "t3_refill");
        check("t3_nbursts_refill", 32'(burst_lens.size()), 32'd3);
        check("t3_len2", 32'(burst_lens[2]), 32'd4);
        sck_run(640 - 96);
        for (int i = 0; i < 20; i++) check("t3_word", rx_word(i), exp_word(src, 20, i));
        rd(3'd3, v);
        check("t3_reg3", v, 32'd20);
        rd(3'd0, v);
        check("t3_underflow", v & 32'h4, 32'd0);
        cs_release();

        // Slow memory: first word underflows and is sent as zeros.
        src = $urandom & 32'h00FF_FFF0;
        mem_delay = 200;
        wr(3'd2, 32'd2);
        addr_log.delete(); burst_lens.delete();
        wr(3'd1, src);
        rx_bits.delete();
        cs_assert();
        sck_run(64);
        check("t4_word0_zero", rx_word(0), 32'd0);
        check("t4_word1", rx_word(1), src ^ KEY);
        rd(3'd0, v);
        check("t4_underflow_set", v & 32'h4, 32'h4);
        wr(3'd0, 32'd1);
        rd(3'd0, v);
        check("t4_underflow_clr", v & 32'h4, 32'd0);
        cs_release();
        mem_delay = 0;

        // CS released after 40 bits.
        src = $urandom & 32'h00FF_FFF0;
        wr(3'd2, 32'd4);
        addr_log.delete(); burst_lens.delete();
        wr(3'd1, src);
        wait_dma(4, "t5_fill");
        rx_bits.delete();
        cs_assert();
        sck_run(40);
        cs_release();
        check("t5_miso_low", {31'd0, MISO}, 32'd0);
        check("t5_word0", rx_word(0), src ^ KEY);
        tmp = (src + 32'd4) ^ KEY;
        for (int j = 0; j < 8; j++) b[j] = rx_bits[32 + j];
        check("t5_word1_lsbyte", {24'd0, b}, {24'd0, tmp[7:0]});
        rd(3'd0, v);
        check("t5_armed_clr", v & 32'h8, 32'd0);
        rd(3'd3, v);
        check("t5_reg3", v, 32'd1);

        // Asynchronous reset in the middle of a burst.
        src = ($urandom & 32'h00FF_FFF0) | 32'h100;
        wr(3'd2, 32'd8);
        addr_log.delete(); burst_lens.delete();
        wr(3'd1, src);
        cyc = 0;
        while (addr_log.size() < 2 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_two_words", {31'd0, addr_log.size() >= 2}, 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("t6_do_read", {31'd0, do_read}, 32'd0);
        check("t6_addr", addr, 32'd0);
        check("t6_miso", {31'd0, MISO}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        rd(3'd3, v);
        check("t6_reg3", v, 32'd0);
        rd(3'd0, v);
        check("t6_reg0", v, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
